frame_fifo_write: RTL and testbench

- Write-side frame engine. Drains the camera-side write FIFO into SDRAM in fixed bursts via the App_wr_en/App_wr_addr/App_wr_data user interface.
- Mirrors the frame read engine: same request/ack handshake, 4-entry base-address select and FIFO-clear protocol.
- Mutually excludes with the read engine via O_wr_busy/App_rd_busy.

---
 rtl/frame_fifo_pkg.sv | 20 ++
 rtl/frame_fifo_write_sync_3ff.sv | 29 ++
 rtl/frame_fifo_write.sv | 187 ++++++++++++++++++
 tb/tb_frame_fifo_write.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_fifo_pkg.sv
// Shared definitions for the frame read/write SDRAM engines.
// State encodings are common to both engines so debug tooling decodes them identically.
package frame_fifo_pkg;

    typedef enum logic [2:0] {
        S_IDLE            = 3'd0,
        S_ACK             = 3'd1,
        S_CHECK_FIFO      = 3'd2,
        S_WRITE_BURST     = 3'd3,
        S_WRITE_BURST_END = 3'd4,
        S_END             = 3'd5
    } frame_state_t;

    localparam logic ONE  = 1'b1;
    localparam logic ZERO = 1'b0;

    localparam logic [31:0] ONE_W32  = 32'd1;
    localparam logic [31:0] ZERO_W32 = 32'd0;

endpackage

// File: rtl/frame_fifo_write_sync_3ff.sv
// Three-flop synchroniser into mem_clk; TAP selects whether the 2nd or 3rd stage is presented.
module sync_3ff #(
    parameter int WIDTH = 1,
    parameter int TAP   = 3
) (
    input  logic             mem_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [3];

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            stage_r[0] <= '0;
            stage_r[1] <= '0;
            stage_r[2] <= '0;
        end else begin
            stage_r[0] <= d;
            stage_r[1] <= stage_r[0];
            stage_r[2] <= stage_r[1];
        end
    end

    assign q = (TAP == 2) ? stage_r[1] : stage_r[2];

endmodule

// File: rtl/frame_fifo_write.sv
// Write-side frame engine: drains the camera write FIFO into SDRAM in fixed-length bursts.
// Shares the request/ack, base-address select and FIFO-clear protocol with the read engine.
module frame_fifo_write
    import frame_fifo_pkg::*;
#(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 21,
    parameter int BURST_BITS    = 9,
    parameter int FIFO_DEPTH    = 512,
    parameter int BURST_SIZE    = 128
) (
    input  logic                     rst,
    input  logic                     mem_clk,
    input  logic                     Sdr_init_done,
    input  logic                     App_rd_busy,
    output logic                     O_wr_busy,
    output logic                     App_wr_en,
    output logic [ADDR_BITS-1:0]     App_wr_addr,
    output logic [MEM_DATA_BITS-1:0] App_wr_data,
    output logic                     fifo_rden,
    input  logic [MEM_DATA_BITS-1:0] fifo_rdata,
    input  logic [9:0]               rdusedw,
    input  logic                     write_req,
    output logic                     write_req_ack,
    output logic                     write_finish,
    input  logic [ADDR_BITS-1:0]     write_addr_0,
    input  logic [ADDR_BITS-1:0]     write_addr_1,
    input  logic [ADDR_BITS-1:0]     write_addr_2,
    input  logic [ADDR_BITS-1:0]     write_addr_3,
    input  logic [1:0]               write_addr_index,
    input  logic [ADDR_BITS-1:0]     write_len,
    output logic                     fifo_aclr
);

    // A burst can never exceed what the FIFO is able to hold.
    localparam int BURST_LIMIT = (BURST_SIZE <= FIFO_DEPTH) ? BURST_SIZE : FIFO_DEPTH;
    localparam int WCNT_BITS   = ADDR_BITS + 1;

    localparam logic [BURST_BITS-1:0] BURST_CNT   = BURST_BITS'(BURST_LIMIT);
    localparam logic [BURST_BITS-1:0] BURST_LAST  = BURST_BITS'(BURST_LIMIT - 1);
    localparam logic [9:0]            USED_THRESH = 10'(BURST_LIMIT);
    localparam logic [WCNT_BITS-1:0]  BURST_WCNT  = WCNT_BITS'(BURST_LIMIT);

    logic                  req_s;
    logic [ADDR_BITS-1:0]  len_sync_s;
    logic [1:0]            index_sync_s;
    logic [ADDR_BITS-1:0]  base_addr_s;

    frame_state_t          state_r;
    logic [ADDR_BITS-1:0]  len_latch_r;
    logic [WCNT_BITS-1:0]  write_cnt_r;
    logic [BURST_BITS-1:0] rd_cnt_r;
    logic [BURST_BITS-1:0] wr_cnt_r;

    sync_3ff #(
        .WIDTH (1),
        .TAP   (3)
    ) u_req_sync (
        .mem_clk (mem_clk),
        .rst     (rst),
        .d       (write_req),
        .q       (req_s)
    );

    // Length and index are quasi-static around a request, so two stages suffice.
    sync_3ff #(
        .WIDTH (ADDR_BITS + 2),
        .TAP   (2)
    ) u_bus_sync (
        .mem_clk (mem_clk),
        .rst     (rst),
        .d       ({write_addr_index, write_len}),
        .q       ({index_sync_s, len_sync_s})
    );

    // Select the frame base address from the synchronised index.
    always_comb begin
        base_addr_s = write_addr_0;
        case (index_sync_s)
            2'd0:    base_addr_s = write_addr_0;
            2'd1:    base_addr_s = write_addr_1;
            2'd2:    base_addr_s = write_addr_2;
            2'd3:    base_addr_s = write_addr_3;
            default: base_addr_s = write_addr_0;
        endcase
    end

    // The FIFO output stage is the data register; gating keeps the bus quiet between strobes.
    assign App_wr_data = App_wr_en ? fifo_rdata : {MEM_DATA_BITS{ZERO}};

    // Frame state machine with all handshake and SDRAM strobes registered.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            len_latch_r   <= '0;
            write_cnt_r   <= '0;
            rd_cnt_r      <= '0;
            wr_cnt_r      <= '0;
            O_wr_busy     <= ZERO;
            App_wr_en     <= ZERO;
            App_wr_addr   <= '0;
            fifo_rden     <= ZERO;
            write_req_ack <= ZERO;
            write_finish  <= ZERO;
            fifo_aclr     <= ZERO;
        end else begin
            App_wr_en    <= fifo_rden;
            write_finish <= ZERO;
            case (state_r)
                S_IDLE: begin
                    write_req_ack <= ZERO;
                    fifo_aclr     <= ZERO;
                    fifo_rden     <= ZERO;
                    if (req_s && Sdr_init_done) begin
                        state_r <= S_ACK;
                    end
                end
                S_ACK: begin
                    fifo_rden <= ZERO;
                    if (req_s) begin
                        write_req_ack <= ONE;
                        fifo_aclr     <= ONE;
                        len_latch_r   <= len_sync_s;
                        App_wr_addr   <= base_addr_s;
                        write_cnt_r   <= '0;
                    end else begin
                        write_req_ack <= ZERO;
                        fifo_aclr     <= ZERO;
                        state_r       <= S_CHECK_FIFO;
                    end
                end
                S_CHECK_FIFO: begin
                    fifo_rden <= ZERO;
                    if (req_s) begin
                        state_r <= S_ACK;
                    end else if ((rdusedw >= USED_THRESH) && !App_rd_busy) begin
                        state_r   <= S_WRITE_BURST;
                        rd_cnt_r  <= '0;
                        wr_cnt_r  <= '0;
                        O_wr_busy <= ONE;
                    end
                end
                S_WRITE_BURST: begin
                    if (rd_cnt_r < BURST_CNT) begin
                        fifo_rden <= ONE;
                        rd_cnt_r  <= rd_cnt_r + BURST_BITS'(1);
                    end else begin
                        fifo_rden <= ZERO;
                    end
                    if (App_wr_en) begin
                        App_wr_addr <= App_wr_addr + ADDR_BITS'(1);
                        wr_cnt_r    <= wr_cnt_r + BURST_BITS'(1);
                        if (wr_cnt_r == BURST_LAST) begin
                            state_r     <= S_WRITE_BURST_END;
                            write_cnt_r <= write_cnt_r + BURST_WCNT;
                            O_wr_busy   <= ZERO;
                        end
                    end
                end
                S_WRITE_BURST_END: begin
                    fifo_rden <= ZERO;
                    // Length is tested after the burst, so a zero length still moves one burst.
                    if (req_s) begin
                        state_r <= S_ACK;
                    end else if (write_cnt_r < {ZERO, len_latch_r}) begin
                        state_r <= S_CHECK_FIFO;
                    end else begin
                        state_r      <= S_END;
                        write_finish <= ONE;
                    end
                end
                S_END: begin
                    fifo_rden <= ZERO;
                    state_r   <= S_IDLE;
                end
                default: begin
                    state_r       <= S_IDLE;
                    fifo_rden     <= ZERO;
                    O_wr_busy     <= ZERO;
                    write_req_ack <= ZERO;
                    fifo_aclr     <= ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_fifo_write.sv
// Scoreboard bench for frame_fifo_write: stimulus queues expected SDRAM writes, a monitor checks them.
module tb_frame_fifo_write;

    typedef struct {
        logic [20:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        rst;
    logic        mem_clk;
    logic        Sdr_init_done;
    logic        App_rd_busy;
    logic        O_wr_busy;
    logic        App_wr_en;
    logic [20:0] App_wr_addr;
    logic [31:0] App_wr_data;
    logic        fifo_rden;
    logic [31:0] fifo_rdata;
    logic [9:0]  rdusedw;
    logic        write_req;
    logic        write_req_ack;
    logic        write_finish;
    logic [20:0] write_addr_0;
    logic [20:0] write_addr_1;
    logic [20:0] write_addr_2;
    logic [20:0] write_addr_3;
    logic [1:0]  write_addr_index;
    logic [20:0] write_len;
    logic        fifo_aclr;

    int   checks;
    int   errors;
    int   finish_cnt;
    int   fin_base;
    int   rden_cnt;
    int   frame_wr;
    int   run_len;
    int   rd_idx;
    exp_t exp_q [$];

    frame_fifo_write dut (
        .rst              (rst),
        .mem_clk          (mem_clk),
        .Sdr_init_done    (Sdr_init_done),
        .App_rd_busy      (App_rd_busy),
        .O_wr_busy        (O_wr_busy),
        .App_wr_en        (App_wr_en),
        .App_wr_addr      (App_wr_addr),
        .App_wr_data      (App_wr_data),
        .fifo_rden        (fifo_rden),
        .fifo_rdata       (fifo_rdata),
        .rdusedw          (rdusedw),
        .write_req        (write_req),
        .write_req_ack    (write_req_ack),
        .write_finish     (write_finish),
        .write_addr_0     (write_addr_0),
        .write_addr_1     (write_addr_1),
        .write_addr_2     (write_addr_2),
        .write_addr_3     (write_addr_3),
        .write_addr_index (write_addr_index),
        .write_len        (write_len),
        .fifo_aclr        (fifo_aclr)
    );

    initial begin
        mem_clk = 1'b0;
        forever #5 mem_clk = ~mem_clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Normal-mode FIFO: word n of a frame (counted from the last clear) is A5000000+n.
    always @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            rd_idx     <= 0;
            fifo_rdata <= 32'h0;
        end else if (fifo_aclr) begin
            rd_idx <= 0;
        end else if (fifo_rden) begin
            fifo_rdata <= 32'hA500_0000 + 32'(rd_idx);
            rd_idx     <= rd_idx + 1;
        end
    end

    // Monitor: pop and compare each SDRAM write, check burst length, count pulses.
    always @(negedge mem_clk) begin
        exp_t e;
        if (write_finish) finish_cnt++;
        if (fifo_rden) rden_cnt++;
        if (rst) begin
            run_len = 0;
        end else if (App_wr_en) begin
            run_len++;
            frame_wr++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h required=none", App_wr_addr);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(App_wr_addr), 64'(e.addr));
                chk("wr_data", 64'(App_wr_data), 64'(e.data));
            end
        end else if (run_len != 0) begin
            chk("burst_len", 64'(run_len), 64'd128);
            run_len = 0;
        end
    end

    task automatic push_frame(input logic [20:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = base + 21'(i);
            e.data = 32'hA500_0000 + 32'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(input logic [1:0] idx, input logic [20:0] len);
        int n;
        @(negedge mem_clk);
        write_addr_index = idx;
        write_len        = len;
        repeat (3) @(negedge mem_clk);
        frame_wr  = 0;
        fin_base  = finish_cnt;
        write_req = 1'b1;
        n = 0;
        while (!write_req_ack && n < 400) begin
            @(negedge mem_clk);
            n++;
        end
        chk("req_ack", 64'(write_req_ack), 64'd1);
        chk("aclr_with_ack", 64'(fifo_aclr), 64'd1);
        write_req = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (frame_wr < target && n < 500) begin
            @(negedge mem_clk);
            #1;
            n++;
        end
        chk("reach_write_count", 64'(frame_wr >= target), 64'd1);
    endtask

    task automatic finish_frame();
        int n;
        int r0;
        n = 0;
        while ((exp_q.size() != 0 || finish_cnt == fin_base) && n < 2000) begin
            @(negedge mem_clk);
            n++;
        end
        repeat (5) @(negedge mem_clk);
        chk("writes_pending", 64'(exp_q.size()), 64'd0);
        chk("finish_pulses", 64'(finish_cnt - fin_base), 64'd1);
        r0 = rden_cnt;
        repeat (20) @(negedge mem_clk);
        chk("idle_no_read", 64'(rden_cnt), 64'(r0));
        chk("idle_busy", 64'(O_wr_busy), 64'd0);
        chk("idle_ack", 64'(write_req_ack), 64'd0);
    endtask

    initial begin
        int r0;
        checks = 0;  errors = 0;  finish_cnt = 0;  fin_base = 0;
        rden_cnt = 0;  frame_wr = 0;  run_len = 0;
        rst = 1'b1;  Sdr_init_done = 1'b0;  App_rd_busy = 1'b0;
        rdusedw = 10'd0;  write_req = 1'b0;
        write_addr_0 = 21'h0;  write_addr_1 = 21'h0;
        write_addr_2 = 21'h0;  write_addr_3 = 21'h0;
        write_addr_index = 2'd0;  write_len = 21'd0;
        repeat (3) @(negedge mem_clk);
        chk("rst_wr_en", 64'(App_wr_en), 64'd0);
        chk("rst_rden", 64'(fifo_rden), 64'd0);
        chk("rst_addr", 64'(App_wr_addr), 64'd0);
        chk("rst_data", 64'(App_wr_data), 64'd0);
        chk("rst_ack", 64'(write_req_ack), 64'd0);
        chk("rst_finish", 64'(write_finish), 64'd0);
        chk("rst_aclr", 64'(fifo_aclr), 64'd0);
        chk("rst_busy", 64'(O_wr_busy), 64'd0);
        rst = 1'b0;
        Sdr_init_done = 1'b1;

        // Basic two-burst frame from base 0x1000
        write_addr_2 = 21'h01000;
        rdusedw = 10'd300;
        push_frame(21'h01000, 256);
        start_frame(2'd2, 21'd256);
        finish_frame();

        // FIFO starvation: 127 words never start a burst, 128 does
        write_addr_1 = 21'h08000;
        rdusedw = 10'd127;
        push_frame(21'h08000, 128);
        start_frame(2'd1, 21'd128);
        r0 = rden_cnt;
        repeat (20) @(negedge mem_clk);
        chk("starved_no_read", 64'(rden_cnt), 64'(r0));
        chk("starved_busy", 64'(O_wr_busy), 64'd0);
        rdusedw = 10'd128;
        @(posedge mem_clk);
        @(posedge mem_clk);
        #1;
        chk("burst_start_2cyc", 64'(fifo_rden), 64'd1);
        finish_frame();

        // Arbitration with the read engine
        write_addr_3 = 21'h20000;
        rdusedw = 10'd400;
        App_rd_busy = 1'b1;
        push_frame(21'h20000, 128);
        start_frame(2'd3, 21'd128);
        r0 = rden_cnt;
        repeat (20) @(negedge mem_clk);
        chk("rd_busy_no_read", 64'(rden_cnt), 64'(r0));
        App_rd_busy = 1'b0;
        wait_writes(10);
        chk("wr_busy_mid_burst", 64'(O_wr_busy), 64'd1);
        App_rd_busy = 1'b1;
        finish_frame();
        App_rd_busy = 1'b0;

        // Re-request during burst 1 of 4: burst completes, new frame at new base
        write_addr_1 = 21'h02000;
        write_addr_3 = 21'h03000;
        rdusedw = 10'd300;
        push_frame(21'h02000, 128);
        start_frame(2'd1, 21'd512);
        wait_writes(10);
        push_frame(21'h03000, 128);
        start_frame(2'd3, 21'd128);
        finish_frame();

        // Address wrap at the top of the SDRAM
        write_addr_0 = 21'h1FFFC0;
        push_frame(21'h1FFFC0, 128);
        start_frame(2'd0, 21'd128);
        finish_frame();

        // Zero length still issues one burst
        write_addr_2 = 21'h00500;
        push_frame(21'h00500, 128);
        start_frame(2'd2, 21'd0);
        finish_frame();

        // Asynchronous reset at the 50th write, then a clean frame
        write_addr_1 = 21'h04000;
        push_frame(21'h04000, 256);
        start_frame(2'd1, 21'd256);
        wait_writes(50);
        #1 rst = 1'b1;
        #1;
        chk("arst_wr_en", 64'(App_wr_en), 64'd0);
        chk("arst_rden", 64'(fifo_rden), 64'd0);
        chk("arst_busy", 64'(O_wr_busy), 64'd0);
        chk("arst_addr", 64'(App_wr_addr), 64'd0);
        chk("arst_data", 64'(App_wr_data), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge mem_clk);
        rst = 1'b0;
        write_addr_0 = 21'h00600;
        push_frame(21'h00600, 128);
        start_frame(2'd0, 21'd128);
        finish_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
